fle_cfg_bank_writer: RTL and testbench

//  Configuration sequencer for one FLE's flat memory bank (NUM_BITS bl/wl pairs).

---
 rtl/fle_cfg_bank_writer.sv | 168 ++++++++++++++++
 tb/tb_fle_cfg_bank_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fle_cfg_bank_writer.sv
// Programming sequencer for one FLE configuration bank: takes config chunks over a
// valid/ready stream and writes them bit by bit (LSB first) through bl/wl pulses.
module fle_cfg_bank_writer #(
  parameter int NUM_BITS = 70,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic                        prog_clk,
  input  logic                        global_resetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DATA_W-1:0]           cfg_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [0:NUM_BITS-1]         bl,
  output logic [0:NUM_BITS-1]         wl,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_BITS)-1:0] bit_idx,
  output logic [2:0]                  state_dbg
);

  localparam int KW   = $clog2(NUM_BITS);
  localparam int SW   = $clog2(DATA_W);
  localparam int MAXC = (WL_PULSE > HOLD_CYC) ? WL_PULSE : HOLD_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [KW-1:0] LAST_K     = KW'(NUM_BITS - 1);
  localparam logic [SW-1:0] LAST_SUB   = SW'(DATA_W - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(WL_PULSE - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [SW-1:0]       sub_q, sub_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   chunk_q, chunk_d;
  logic                cfg_ready_d, busy_d, done_d;
  logic [0:NUM_BITS-1] bl_d, wl_d;

  // Handshake: a chunk transfers on a rising edge with cfg_valid & cfg_ready.
  // cfg_ready is registered, high for the whole LOAD state and independent of
  // cfg_valid; an abort on the same edge drops that chunk.

  always_ff @(posedge prog_clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      sub_q     <= '0;
      cnt_q     <= '0;
      chunk_q   <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bl        <= '0;
      wl        <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sub_q     <= sub_d;
      cnt_q     <= cnt_d;
      chunk_q   <= chunk_d;
      cfg_ready <= cfg_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      bl        <= bl_d;
      wl        <= wl_d;
    end
  end

  // sub_q tracks k modulo DATA_W so no divider is needed to find chunk boundaries
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    chunk_d = chunk_q;
    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      sub_d   = '0;
      cnt_d   = '0;
      chunk_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            k_d     = '0;
            sub_d   = '0;
          end
        end
        S_LOAD: begin
          if (cfg_valid && cfg_ready) begin
            chunk_d = cfg_data;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LOAD;
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (k_q == LAST_K) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
            if (sub_q == LAST_SUB) begin
              sub_d   = '0;
              state_d = S_LOAD;
            end else begin
              sub_d   = sub_q + 1'b1;
              state_d = S_SETUP;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          k_d     = '0;
          sub_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so that every output leaves a flop
  always_comb begin
    cfg_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    bl_d        = '0;
    wl_d        = '0;
    case (state_d)
      S_SETUP: bl_d[k_d] = chunk_d[sub_d];
      S_PULSE: begin
        bl_d      = bl;
        wl_d[k_d] = 1'b1;
      end
      S_HOLD:  bl_d = bl;
      default: ;
    endcase
  end

  assign bit_idx   = k_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fle_cfg_bank_writer.sv
// Bench for fle_cfg_bank_writer: control-edge vector table, directed programming
// passes (abort, reset, stalls) and randomized passes against a bit-list model.
module tb_fle_cfg_bank_writer;

  localparam int NUM_BITS = 70;
  localparam int DATA_W   = 8;
  localparam int WL_PULSE = 2;
  localparam int HOLD_CYC = 1;
  localparam int KW       = $clog2(NUM_BITS);
  localparam int NCHUNK   = (NUM_BITS + DATA_W - 1) / DATA_W;
  localparam int BIT_CYC  = 1 + WL_PULSE + HOLD_CYC;

  logic                prog_clk = 1'b0;
  logic                global_resetn;
  logic                start, abort, cfg_valid;
  logic [DATA_W-1:0]   cfg_data;
  logic                cfg_ready;
  logic [0:NUM_BITS-1] bl, wl;
  logic                busy, done;
  logic [KW-1:0]       bit_idx;
  logic [2:0]          state_dbg;

  // clock / reset
  always #5 prog_clk = ~prog_clk;

  fle_cfg_bank_writer #(
    .NUM_BITS(NUM_BITS), .DATA_W(DATA_W), .WL_PULSE(WL_PULSE), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .prog_clk(prog_clk), .global_resetn(global_resetn), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .bl(bl), .wl(wl), .busy(busy), .done(done), .bit_idx(bit_idx), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {bit index, bit value} in the order the bank must be written
  logic [KW:0]       exp_q[$];
  logic [DATA_W-1:0] chunk_mem[NCHUNK];
  int                stall_mem[NCHUNK];

  typedef struct packed {
    logic              start;
    logic              abort;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              e_busy;
    logic              e_ready;
    logic              e_done;
    logic              e_wl0;
    logic              e_bl0;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [0:NUM_BITS-1] one_at(input int idx, input logic v);
    logic [0:NUM_BITS-1] r;
    r = '0;
    r[idx] = v;
    return r;
  endfunction

  task automatic wait_cycle();
    @(posedge prog_clk);
    @(negedge prog_clk);
  endtask

  // driver + monitor for one programming pass; called at a negedge
  task automatic run_pass(input string tag, input int abort_bit, input int reset_bit,
                          input bit noise, output int done_cyc);
    int cyc, ci, stall_left, hs, exp_done, pulse_len, idx;
    bit finished, prev_wl_any, wl_any;
    logic seen_done;
    logic [0:NUM_BITS-1] prev_bl;
    logic [KW:0] ev;
    exp_q.delete();
    cyc = 0; ci = 0; hs = 0; pulse_len = 0; finished = 0; prev_wl_any = 0;
    prev_bl = bl; done_cyc = -1;
    stall_left = stall_mem[0];
    exp_done = 1 + NCHUNK + NUM_BITS * BIT_CYC;
    for (int c = 0; c < NCHUNK; c++) exp_done += stall_mem[c];
    start = 1'b1;
    abort = 1'b0;
    while (!finished) begin
      if (ci < NCHUNK) begin
        if (stall_left > 0) begin
          cfg_valid = 1'b0;
          if (cfg_ready) begin
            stall_left--;
            check({tag, "_stall_wl"}, 128'(wl), 128'(0));
            check({tag, "_stall_idx"}, 128'(bit_idx), 128'(ci * DATA_W));
          end
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = chunk_mem[ci];
          if (cfg_ready) begin
            for (int b = 0; b < DATA_W; b++)
              if (ci * DATA_W + b < NUM_BITS)
                exp_q.push_back({KW'(ci * DATA_W + b), chunk_mem[ci][b]});
            ci++;
            hs++;
            stall_left = (ci < NCHUNK) ? stall_mem[ci] : 0;
          end
        end
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = DATA_W'($urandom);
        check({tag, "_no_extra_load"}, 128'(cfg_ready), 128'(0));
      end
      @(posedge prog_clk);
      cyc++;
      @(negedge prog_clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wl_any = |wl;
      check({tag, "_wl_onehot0"}, 128'($onehot0(wl)), 128'(1));
      if (wl_any) check({tag, "_bl_stable_under_wl"}, 128'(bl), 128'(prev_bl));
      if (wl_any && !prev_wl_any) begin
        idx = 0;
        for (int i = 0; i < NUM_BITS; i++) if (wl[i]) idx = i;
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check({tag, "_wl_idx"}, 128'(idx), 128'(ev[KW:1]));
        check({tag, "_bl_at_pulse"}, 128'(bl), 128'(one_at(idx, ev[0])));
        check({tag, "_bit_idx"}, 128'(bit_idx), 128'(idx));
        pulse_len = 1;
        if (idx == abort_bit) begin
          abort = 1'b1;
          start = 1'b0;
          wait_cycle();
          check({tag, "_abort_wl"}, 128'(wl), 128'(0));
          check({tag, "_abort_bl"}, 128'(bl), 128'(0));
          check({tag, "_abort_busy"}, 128'(busy), 128'(0));
          check({tag, "_abort_idx"}, 128'(bit_idx), 128'(0));
          abort = 1'b0;
          cfg_valid = 1'b1;
          seen_done = done;
          repeat (20) begin
            wait_cycle();
            seen_done = seen_done | done;
          end
          check({tag, "_abort_no_done"}, 128'(seen_done), 128'(0));
          check({tag, "_abort_stays_idle"}, 128'(busy), 128'(0));
          finished = 1;
        end else if (idx == reset_bit) begin
          start = 1'b0;
          #2 global_resetn = 1'b0;
          #1;
          check({tag, "_rst_wl_async"}, 128'(wl), 128'(0));
          check({tag, "_rst_bl_async"}, 128'(bl), 128'(0));
          check({tag, "_rst_busy"}, 128'(busy), 128'(0));
          check({tag, "_rst_ready"}, 128'(cfg_ready), 128'(0));
          check({tag, "_rst_idx"}, 128'(bit_idx), 128'(0));
          @(negedge prog_clk);
          global_resetn = 1'b1;
          wait_cycle();
          check({tag, "_rst_idle"}, 128'(busy), 128'(0));
          finished = 1;
        end
      end else if (wl_any) begin
        pulse_len++;
      end
      if (!finished && !wl_any && prev_wl_any)
        check({tag, "_pulse_len"}, 128'(pulse_len), 128'(WL_PULSE));
      if (!finished && done) begin
        done_cyc = cyc;
        check({tag, "_done_cycle"}, 128'(cyc), 128'(exp_done));
        check({tag, "_handshakes"}, 128'(hs), 128'(NCHUNK));
        check({tag, "_all_bits_written"}, 128'(exp_q.size()), 128'(0));
        check({tag, "_done_bl"}, 128'(bl), 128'(0));
        check({tag, "_done_busy"}, 128'(busy), 128'(1));
        start = 1'b0;
        cfg_valid = 1'b0;
        wait_cycle();
        check({tag, "_done_single"}, 128'(done), 128'(0));
        check({tag, "_idle_after_done"}, 128'(busy), 128'(0));
        finished = 1;
      end
      if (!finished && cyc > exp_done + 20) begin
        check({tag, "_timeout"}, 128'(cyc), 128'(exp_done));
        finished = 1;
      end
      prev_wl_any = wl_any;
      prev_bl = bl;
    end
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int dc;
    // {start, abort, valid, data, busy, ready, done, wl[0], bl[0]} applied from IDLE
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    global_resetn = 1'b0;
    repeat (2) @(negedge prog_clk);
    check("reset_bl", 128'(bl), 128'(0));
    check("reset_wl", 128'(wl), 128'(0));
    check("reset_ready", 128'(cfg_ready), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_bit_idx", 128'(bit_idx), 128'(0));
    check("reset_state_idle", 128'(state_dbg), 128'(0));
    global_resetn = 1'b1;
    @(negedge prog_clk);

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; abort = vecs[i].abort;
      cfg_valid = vecs[i].valid; cfg_data = vecs[i].data;
      wait_cycle();
      check($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].e_busy));
      check($sformatf("vec%0d_ready", i), 128'(cfg_ready), 128'(vecs[i].e_ready));
      check($sformatf("vec%0d_done", i), 128'(done), 128'(vecs[i].e_done));
      check($sformatf("vec%0d_wl", i), 128'(wl), 128'(one_at(0, vecs[i].e_wl0)));
      check($sformatf("vec%0d_bl", i), 128'(bl), 128'(one_at(0, vecs[i].e_bl0)));
      check($sformatf("vec%0d_bit_idx", i), 128'(bit_idx), 128'(0));
    end
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    wait_cycle();

    // all ones, cfg_valid held, no stalls
    foreach (chunk_mem[c]) begin chunk_mem[c] = 8'hFF; stall_mem[c] = 0; end
    run_pass("s1_ones", -1, -1, 1'b0, dc);
    check("s1_latency", 128'(dc), 128'(290));

    // sparse pattern in the first chunk only
    foreach (chunk_mem[c]) chunk_mem[c] = 8'h00;
    chunk_mem[0] = 8'hA5;
    run_pass("s2_a5", -1, -1, 1'b0, dc);

    // source withholds chunk 2 for 10 LOAD cycles
    foreach (chunk_mem[c]) begin chunk_mem[c] = 8'hFF; stall_mem[c] = 0; end
    stall_mem[1] = 10;
    run_pass("s3_stall", -1, -1, 1'b0, dc);
    check("s3_latency", 128'(dc), 128'(300));

    foreach (chunk_mem[c]) begin chunk_mem[c] = DATA_W'($urandom); stall_mem[c] = 0; end
    run_pass("s4_abort", 30, -1, 1'b0, dc);
    run_pass("s4_after", -1, -1, 1'b0, dc);

    foreach (chunk_mem[c]) chunk_mem[c] = DATA_W'($urandom);
    run_pass("s5_reset", -1, 12, 1'b0, dc);
    run_pass("s5_after", -1, -1, 1'b0, dc);

    // random data, random stalls, start toggling while busy
    repeat (3) begin
      foreach (chunk_mem[c]) begin
        chunk_mem[c] = DATA_W'($urandom);
        stall_mem[c] = $urandom_range(0, 3);
      end
      run_pass("rand", -1, -1, 1'b1, dc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
